// File: rtl/pilot_extract_if.sv
// Carrier stream link: cycle/strobe/write qualifiers with data forward, accept backward.
interface pilot_extract_if #(parameter int W = 16);
  logic [2*W-1:0] dat;
  logic           we;
  logic           stb;
  logic           cyc;
  logic           ack;

  modport master (output dat, we, stb, cyc, input ack);
  modport slave  (input dat, we, stb, cyc, output ack);
endinterface

// File: rtl/pilot_extract.sv
// Splits a 52-carrier symbol stream into forwarded data carriers and a
// polarity-corrected pilot sum, one sum per completed symbol.
//
// state    | meaning
// ST_IDLE  | no frame open; accepted samples are consumed and dropped
// ST_FRAME | frame open; samples indexed, forwarded or summed
module pilot_extract #(
  parameter int W  = 16,
  parameter int SW = 18
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  pilot_extract_if.slave  up,
  pilot_extract_if.master dn,
  output logic [2*SW-1:0] PLT_SUM_O,
  output logic            PLT_VAL_O
);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t                state_q, state_d;
  logic                  cyc_q;
  logic [6:0]            idx_q;
  logic [6:0]            lfsr_q;
  logic signed [SW-1:0]  acc_re_q, acc_im_q;
  logic [2*W-1:0]        dat_q;
  logic                  stb_q;
  logic                  cyc_o_q;

  logic                  in_val, out_halt, accept, frame_start, take;
  logic [6:0]            idx_eff, lfsr_eff;
  logic                  pol, neg, is_pilot;
  logic signed [SW-1:0]  pil_re, pil_im, sum_re, sum_im;

  assign in_val   = up.we & up.stb & up.cyc;
  assign out_halt = stb_q & ~dn.ack;
  assign accept   = in_val & ~out_halt;
  assign up.ack   = accept;

  assign dn.dat = dat_q;
  assign dn.stb = stb_q;
  assign dn.cyc = cyc_o_q;
  assign dn.we  = cyc_o_q;

  assign pil_re = SW'($signed(up.dat[W-1:0]));
  assign pil_im = SW'($signed(up.dat[2*W-1:W]));

  always_comb begin
    state_d     = state_q;
    frame_start = up.cyc & ~cyc_q;
    // a sample arriving on the frame-start cycle is idx 0 under the fresh seed
    idx_eff     = frame_start ? 7'd0 : idx_q;
    lfsr_eff    = frame_start ? 7'h7f : lfsr_q;
    pol         = lfsr_eff[6] ^ lfsr_eff[3];
    is_pilot    = idx_eff inside {7'd6, 7'd20, 7'd31, 7'd45};
    neg         = (idx_eff == 7'd20) ^ pol;
    take        = accept & (frame_start | (state_q == ST_FRAME));
    sum_re      = neg ? (acc_re_q - pil_re) : (acc_re_q + pil_re);
    sum_im      = neg ? (acc_im_q - pil_im) : (acc_im_q + pil_im);
    if (frame_start)
      state_d = ST_FRAME;
    else if (!up.cyc)
      state_d = ST_IDLE;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b1;
      idx_q     <= '0;
      lfsr_q    <= 7'h7f;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      cyc_o_q   <= 1'b0;
      PLT_SUM_O <= '0;
      PLT_VAL_O <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= up.cyc;
      PLT_VAL_O <= 1'b0;

      if (frame_start) begin
        idx_q    <= '0;
        lfsr_q   <= 7'h7f;
        acc_re_q <= '0;
        acc_im_q <= '0;
      end

      if (take) begin
        if (idx_eff == 7'd51) begin
          idx_q  <= '0;
          lfsr_q <= {lfsr_eff[5:0], pol};
        end else begin
          idx_q  <= idx_eff + 7'd1;
          lfsr_q <= lfsr_eff;
        end
        if (is_pilot) begin
          acc_re_q <= sum_re;
          acc_im_q <= sum_im;
          if (idx_eff == 7'd45) begin
            PLT_SUM_O <= {sum_im, sum_re};
            PLT_VAL_O <= 1'b1;
          end
        end else if (idx_eff == 7'd0) begin
          acc_re_q <= '0;
          acc_im_q <= '0;
        end
      end

      // pilots leave a bubble: strobe drops once pending data is taken
      if (!out_halt) begin
        if (take && !is_pilot) begin
          dat_q <= up.dat;
          stb_q <= 1'b1;
        end else begin
          stb_q <= 1'b0;
        end
      end

      if (take)
        cyc_o_q <= 1'b1;
      else if (!up.cyc && !stb_q)
        cyc_o_q <= 1'b0;
    end
  end

endmodule

// File: doc/pilot_extract.md
PILOT_EXTRACT -- requirements
Module: pilot_extract

Interface
REQ-001 Parameter: W, 16, bit width of each real/imaginary half of a carrier sample.
REQ-002 Parameter: SW, 18, bit width of each half of the pilot-sum accumulator.
REQ-003 CLK_I  in  1  sole clock; all state on rising edge.
REQ-004 RST_I  in  1  reset, asynchronous and active-high.
REQ-005 DAT_I  in  2W  equalized carrier, {Im[2W-1:W], Re[W-1:0]}, two's complement.
REQ-006 WE_I, STB_I, CYC_I  in  1 each  upstream write strobe, data strobe, frame cycle.
REQ-007 ACK_O  out  1  input accept.
REQ-008 DAT_O  out  2W  data carrier, same format as DAT_I.
REQ-009 CYC_O, STB_O, WE_O  out  1 each  downstream frame cycle, data strobe, write (WE_O = CYC_O).
REQ-010 ACK_I  in  1  downstream accept.
REQ-011 PLT_SUM_O  out  2SW  polarity-corrected pilot sum, {Im, Re}, signed.
REQ-012 PLT_VAL_O  out  1  one-cycle pulse, PLT_SUM_O valid.

Function
REQ-013 in_val = WE_I & STB_I & CYC_I; out_halt = STB_O & ~ACK_I; ACK_O = in_val & ~out_halt (combinational); a sample is accepted on a cycle with ACK_O=1.
REQ-014 Input carrier order per symbol, 52 samples: idx 0..25 = carriers +1..+26, idx 26..51 = carriers -26..-1.
REQ-015 Pilot indices: 6 (+7), 20 (+21), 31 (-21), 45 (-7); all other 48 indices are data.
REQ-016 7-bit carrier index counter increments per accepted sample, wraps 51->0, cleared on frame start (CYC_I rising edge detected by a registered copy of CYC_I).
REQ-017 Accepted data sample -> DAT_O loaded and STB_O=1 on next cycle; latency 1 cycle; samples forwarded in arrival order.
REQ-018 While out_halt, DAT_O and STB_O hold; STB_O drops to 0 the cycle after ACK_I if no new data sample was accepted.
REQ-019 Accepted pilot sample -> not forwarded; STB_O deasserts after pending data is acknowledged (gap in stream).
REQ-020 Polarity LFSR: 7 bits, seeded 7'b1111111 at frame start; bit p = x7 xor x4, shifted in; advanced once per symbol on idx wrap 51->0; p=0 means +1, p=1 means -1 (yields 1,1,1,1,-1,-1,-1,1,...).
REQ-021 Pilot sign per pilot = base x polarity; base = +1 for idx 6, 31, 45 and -1 for idx 20.
REQ-022 Accumulator: cleared at idx 0 of each symbol; each pilot sample sign-extended to SW and added (sign +1) or subtracted (sign -1), Re and Im independently; no saturation, SW gives 2 bits headroom.
REQ-023 On acceptance of idx 45 (last pilot), the final sum is registered into PLT_SUM_O and PLT_VAL_O pulses 1 cycle, next cycle; PLT_SUM_O holds until next symbol's update.
REQ-024 CYC_O set on first accepted sample after frame start; cleared when CYC_I=0 and STB_O=0.
REQ-025 A partial symbol at CYC_I fall is discarded: no PLT_VAL_O pulse; next frame restarts idx 0 and LFSR seed.
REQ-026 Frame start and acceptance in same cycle: sample treated as idx 0 of new frame.

Reset
REQ-027 RST_I=1 asynchronously forces: DAT_O=0, STB_O=0, CYC_O=0, PLT_SUM_O=0, PLT_VAL_O=0, idx=0, accumulator=0, LFSR=7'b1111111, CYC_I copy=1.
REQ-028 ACK_O is 0 during reset only via out_halt=0 and inputs; upstream holds CYC_I=0 during reset.
REQ-029 Reset mid-symbol aborts all pending output; after release the block waits for a new CYC_I rising edge.

Verification
REQ-030 One symbol, DAT_I = idx in Re, Im=0, ACK_I=1 -> 48 STB_O beats, Re values 0..51 skipping 6,20,31,45; latency 1 cycle each.
REQ-031 Symbol 0, all pilots Re=0x0100, Im=0 -> signs +,-,+,+ -> PLT_SUM_O Re=0x00200, Im=0, single PLT_VAL_O pulse after idx 45.
REQ-032 Five symbols with identical pilots Re=0x0100 -> sums 0x200,0x200,0x200,0x200, then symbol 4 (p=-1) Re = -0x200 (0x3FE00).
REQ-033 ACK_I held 0 for 3 cycles mid-stream -> ACK_O=0, DAT_O stable, no sample lost or duplicated.
REQ-034 CYC_I dropped at idx 30, then new frame -> no PLT_VAL_O for aborted symbol; new frame sum uses p0=+1.
REQ-035 RST_I asserted mid-symbol without clock edge -> all outputs 0 immediately.
